fitness_eval: RTL

Upstream feeder for the best-chromosome tracker in the GA datapath. On a start pulse it scans the population memory two chromosomes per cycle and computes fitness f(x) = |x^3 - TARGET|. It presents chromosome/fitness pairs, plus the second-slot enable, to the tracker's fitness1/fitness2/chrom1/chrom2/enable_second inputs. It also drives the tracker's synchronous active-high clear. Lower fitness is better; 0 is a perfect match.

---
 rtl/ga_pkg.sv | 19 +
 rtl/fitness_pipe.sv | 72 +++++++
 rtl/fitness_eval.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// Shared GA datapath definitions.
//   CHROM_WIDTH_DEF / FITNESS_WIDTH_DEF : default widths for feeder and tracker
//   FIT_INVALID                         : all-ones fitness, never beats a real value
//   fe_state_e                          : fitness_eval scan FSM states
package ga_pkg;

  localparam int unsigned CHROM_WIDTH_DEF   = 8;
  localparam int unsigned FITNESS_WIDTH_DEF = 27;

  localparam logic [FITNESS_WIDTH_DEF-1:0] FIT_INVALID = '1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } fe_state_e;

endpackage

// File: rtl/fitness_pipe.sv
// Three-stage fitness pipeline: x -> x^2 -> x^3 -> |x^3 - TARGET|.
//   clk, reset : clock, async active-low reset
//   in_valid   : x carries a real chromosome this cycle
//   x          : chromosome (memory read data)
//   out_valid  : fitness/chrom hold a real result
//   chrom      : chromosome of the last valid result (held across bubbles)
//   fitness    : fitness, all-ones whenever out_valid is low
module fitness_pipe import ga_pkg::*; #(
  parameter int unsigned                  CHROM_WIDTH   = CHROM_WIDTH_DEF,
  parameter int unsigned                  FITNESS_WIDTH = FITNESS_WIDTH_DEF,
  parameter logic [FITNESS_WIDTH-1:0]     TARGET        = FITNESS_WIDTH'(1_000_000)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [CHROM_WIDTH-1:0]   x,
  output logic                     out_valid,
  output logic [CHROM_WIDTH-1:0]   chrom,
  output logic [FITNESS_WIDTH-1:0] fitness
);

  localparam int unsigned SqW   = 2 * CHROM_WIDTH;
  localparam int unsigned CubeW = 3 * CHROM_WIDTH;

  logic                     s1_valid_q, s2_valid_q, s3_valid_q;
  logic [CHROM_WIDTH-1:0]   s1_x_q, s2_x_q, s3_chrom_q;
  logic [SqW-1:0]           s1_sq_q, sq_d;
  logic [CubeW-1:0]         s2_cube_q, cube_d;
  logic [FITNESS_WIDTH-1:0] cube_ext, fit_d, s3_fit_q;

  always_comb begin
    sq_d     = SqW'(x) * SqW'(x);
    cube_d   = CubeW'(s1_sq_q) * CubeW'(s1_x_q);
    cube_ext = FITNESS_WIDTH'(s2_cube_q);
    fit_d    = (cube_ext >= TARGET) ? (cube_ext - TARGET) : (TARGET - cube_ext);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_sq_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_cube_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_chrom_q <= '0;
      s3_fit_q   <= '1;
    end else begin
      s1_valid_q <= in_valid;
      s1_x_q     <= x;
      s1_sq_q    <= sq_d;
      s2_valid_q <= s1_valid_q;
      s2_x_q     <= s1_x_q;
      s2_cube_q  <= cube_d;
      s3_valid_q <= s2_valid_q;
      // Bubbles present all-ones so the strict-less-than tracker ignores them;
      // chrom keeps its last real value.
      if (s2_valid_q) begin
        s3_chrom_q <= s2_x_q;
        s3_fit_q   <= fit_d;
      end else begin
        s3_fit_q   <= '1;
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign chrom     = s3_chrom_q;
  assign fitness   = s3_fit_q;

endmodule

// File: rtl/fitness_eval.sv
// Population scanner feeding the best-chromosome tracker.
//   clk, reset          : clock, async active-low reset
//   start               : begin a scan (sampled only when idle)
//   busy, done          : scan in progress / one-cycle end-of-scan pulse
//   rd_addr1, rd_addr2  : memory addresses for pair k (2k, 2k+1 or 0 if absent)
//   rd_data1, rd_data2  : memory data, one cycle after the address
//   best_clr            : one-cycle tracker clear at the start of a scan
//   chrom1/2, fitness1/2, enable_second : tracker inputs
//   eval_valid          : slot 1 holds a real result
module fitness_eval import ga_pkg::*; #(
  parameter int unsigned              CHROM_WIDTH   = CHROM_WIDTH_DEF,
  parameter int unsigned              FITNESS_WIDTH = FITNESS_WIDTH_DEF,
  parameter int unsigned              POP_SIZE      = 16,
  parameter int unsigned              ADDR_WIDTH    = 4,
  parameter logic [FITNESS_WIDTH-1:0] TARGET        = FITNESS_WIDTH'(1_000_000)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_WIDTH-1:0]    rd_addr1,
  output logic [ADDR_WIDTH-1:0]    rd_addr2,
  input  logic [CHROM_WIDTH-1:0]   rd_data1,
  input  logic [CHROM_WIDTH-1:0]   rd_data2,
  output logic                     best_clr,
  output logic [CHROM_WIDTH-1:0]   chrom1,
  output logic [CHROM_WIDTH-1:0]   chrom2,
  output logic [FITNESS_WIDTH-1:0] fitness1,
  output logic [FITNESS_WIDTH-1:0] fitness2,
  output logic                     enable_second,
  output logic                     eval_valid
);

  localparam int unsigned NumPairs = (POP_SIZE + 1) / 2;
  localparam int unsigned PairW    = (NumPairs > 1) ? $clog2(NumPairs) : 1;
  localparam logic [PairW-1:0] LastPair = PairW'(NumPairs - 1);

  function automatic logic [ADDR_WIDTH-1:0] even_addr(input int unsigned k);
    return ADDR_WIDTH'(2 * k);
  endfunction

  // Missing odd slot (odd POP_SIZE, last pair) reads address 0.
  function automatic logic [ADDR_WIDTH-1:0] odd_addr(input int unsigned k);
    return ((2 * k + 1) < POP_SIZE) ? ADDR_WIDTH'(2 * k + 1) : '0;
  endfunction

  fe_state_e             state_q, state_d;
  logic [PairW-1:0]      pair_q, pair_d;
  logic [1:0]            drain_q, drain_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic                  rd_valid1_q, rd_valid1_d, rd_valid2_q, rd_valid2_d;

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    drain_d = drain_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          pair_d  = '0;
          addr1_d = even_addr(0);
          addr2_d = odd_addr(0);
        end
      end
      StFetch: begin
        if (pair_q == LastPair) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          pair_d  = pair_q + 1'b1;
          addr1_d = even_addr(int'(pair_q) + 1);
          addr2_d = odd_addr(int'(pair_q) + 1);
        end
      end
      // Four cycles after the last issue the final pair leaves the pipe.
      StDrain: begin
        if (drain_q == 2'd3) state_d = StDone;
        else                 drain_d = drain_q + 2'd1;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Valid bits line up with memory data, one cycle after the address.
  always_comb begin
    rd_valid1_d = (state_q == StFetch);
    rd_valid2_d = (state_q == StFetch) && ((2 * int'(pair_q) + 1) < int'(POP_SIZE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pair_q      <= '0;
      drain_q     <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      rd_valid1_q <= 1'b0;
      rd_valid2_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_q      <= pair_d;
      drain_q     <= drain_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      rd_valid1_q <= rd_valid1_d;
      rd_valid2_q <= rd_valid2_d;
    end
  end

  assign busy     = (state_q == StFetch) || (state_q == StDrain);
  assign done     = (state_q == StDone);
  assign best_clr = (state_q == StFetch) && (pair_q == '0);
  assign rd_addr1 = addr1_q;
  assign rd_addr2 = addr2_q;

  fitness_pipe #(
    .CHROM_WIDTH  (CHROM_WIDTH),
    .FITNESS_WIDTH(FITNESS_WIDTH),
    .TARGET       (TARGET)
  ) u_pipe1 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_valid1_q),
    .x        (rd_data1),
    .out_valid(eval_valid),
    .chrom    (chrom1),
    .fitness  (fitness1)
  );

  fitness_pipe #(
    .CHROM_WIDTH  (CHROM_WIDTH),
    .FITNESS_WIDTH(FITNESS_WIDTH),
    .TARGET       (TARGET)
  ) u_pipe2 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_valid2_q),
    .x        (rd_data2),
    .out_valid(enable_second),
    .chrom    (chrom2),
    .fitness  (fitness2)
  );

endmodule
